display_scan_n: RTL and testbench

DISPLAY_SCAN_N -- requirements
Module: display_scan_n

---
 rtl/display_scan_n_pkg.sv | 37 +++
 rtl/display_scan_n_seg7_decode.sv | 13 +
 rtl/display_scan_n.sv | 131 +++++++++++++
 tb/tb_display_scan_n.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_scan_n_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: hex glyphs, blank pattern, width helper.
package display_scan_n_pkg;

    typedef logic [6:0] seg_t;

    // Segment bit order is {A,B,C,D,E,F,G}; a 1 lights the segment.
    localparam seg_t SEG_OFF = 7'h00;

    localparam seg_t SEG_HEX [16] = '{
        7'h7E,  // 0
        7'h30,  // 1
        7'h6D,  // 2
        7'h79,  // 3
        7'h33,  // 4
        7'h5B,  // 5
        7'h5F,  // 6
        7'h70,  // 7
        7'h7F,  // 8
        7'h7B,  // 9
        7'h77,  // A
        7'h1F,  // b
        7'h4E,  // C
        7'h3D,  // d
        7'h4F,  // E
        7'h47   // F
    };

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/display_scan_n_seg7_decode.sv
// Hex nibble to active-high seven-segment glyph.
// Latency: combinational. Backpressure: none.
// Polarity is left to the caller so the glyph table stays in one form.
module seg7_decode
    import display_scan_n_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       pattern
);

    assign pattern = SEG_HEX[nibble];

endmodule

// File: rtl/display_scan_n.sv
// Time-multiplexed seven-segment scanner with frame-atomic double-buffered digit updates.
// Latency: outputs registered, one cycle behind the scan index and active digit registers.
// Backpressure: none; load is a fire-and-forget strobe, the newest load before a wrap wins.
module display_scan_n
    import display_scan_n_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 2**19,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_values,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int PW = clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
            $error("display_scan_n: NUM_DIGITS must be 1..8");
        end
        if (SCAN_DIV < 2) begin : g_bad_div
            $error("display_scan_n: SCAN_DIV must be at least 2");
        end
    endgenerate

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;
    logic          tick;
    logic          wrap;

    logic [NUM_DIGITS-1:0][3:0] stage_val;
    logic [NUM_DIGITS-1:0]      stage_dp;
    logic [NUM_DIGITS-1:0]      stage_blank;
    logic [NUM_DIGITS-1:0][3:0] act_val;
    logic [NUM_DIGITS-1:0]      act_dp;
    logic [NUM_DIGITS-1:0]      act_blank;
    logic                       pending;

    seg_t                  pattern;
    seg_t                  seg_hi;
    logic                  dp_hi;
    logic [NUM_DIGITS-1:0] en_hi;

    assign tick      = (presc == PRESC_LAST);
    assign wrap      = tick && (idx == IDX_LAST);
    assign presc_nxt = tick ? '0 : presc + 1'b1;
    assign idx_nxt   = wrap ? '0 : (tick ? idx + 1'b1 : idx);

    // frame_done is computed from next-state so it is high during the wrap cycle itself,
    // which lets a load aligned to frame_done land directly in the active registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc      <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            presc      <= presc_nxt;
            idx        <= idx_nxt;
            frame_done <= (presc_nxt == PRESC_LAST) && (idx_nxt == IDX_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_val   <= '0;
            stage_dp    <= '0;
            stage_blank <= '1;
            act_val     <= '0;
            act_dp      <= '0;
            act_blank   <= '1;
            pending     <= 1'b0;
        end else begin
            if (load) begin
                stage_val   <= digit_values;
                stage_dp    <= dp_in;
                stage_blank <= blank_in;
            end
            if (wrap) begin
                pending <= 1'b0;
                if (load) begin
                    act_val   <= digit_values;
                    act_dp    <= dp_in;
                    act_blank <= blank_in;
                end else if (pending) begin
                    act_val   <= stage_val;
                    act_dp    <= stage_dp;
                    act_blank <= stage_blank;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .nibble  (act_val[idx]),
        .pattern (pattern)
    );

    always_comb begin
        en_hi  = NUM_DIGITS'(1) << idx;
        seg_hi = act_blank[idx] ? SEG_OFF : pattern;
        dp_hi  = act_dp[idx] & ~act_blank[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg      <= SEG_OFF ^ {7{ACTIVE_LOW}};
            dp       <= ACTIVE_LOW;
            digit_en <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            seg      <= seg_hi ^ {7{ACTIVE_LOW}};
            dp       <= dp_hi ^ ACTIVE_LOW;
            digit_en <= en_hi ^ {NUM_DIGITS{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_display_scan_n.sv
// Directed plus randomized bench for display_scan_n (4 digits, 4-cycle dwell, common anode).
module tb_display_scan_n;

    localparam int ND    = 4;
    localparam int SD    = 4;
    localparam int FRAME = ND * SD;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  b;
    } img_t;

    localparam img_t RST_IMG = '{v: 16'h0000, d: 4'h0, b: 4'hF};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digit_values = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_en;
    logic        frame_done;

    int    checks = 0;
    int    errors = 0;
    string phase = "init";

    // Reference state: k counts clock edges since reset was released.
    int   k = 0;
    bit   rst_edge = 1'b1;
    bit   pending = 1'b0;
    img_t stage = RST_IMG;
    img_t act = RST_IMG;
    img_t shown = RST_IMG;
    int   fdn;

    display_scan_n #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .digit_values (digit_values),
        .dp_in        (dp_in),
        .blank_in     (blank_in),
        .load         (load),
        .seg          (seg),
        .dp           (dp),
        .digit_en     (digit_en),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Segment sets {A..G} for each hex glyph, lit = 1.
    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;
            4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;
            4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;
            4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;
            4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;
            4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;
            4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s [%s k=%0d] observed=%0h expected=%0h", tag, phase, k, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int         d;
        logic [3:0] one;
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [3:0] exp_en;
        logic       exp_fd;
        one = 4'b0001;
        if (rst_edge) begin
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            exp_en  = 4'hF;
            exp_fd  = 1'b0;
        end else begin
            d      = ((k - 1) / SD) % ND;
            exp_en = ~(one << d);
            if (shown.b[d]) begin
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_seg = ~hexseg(shown.v[4*d +: 4]);
                exp_dp  = ~shown.d[d];
            end
            exp_fd = (((k + 1) % FRAME) == 0);
        end
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp", 32'(dp), 32'(exp_dp));
        check("digit_en", 32'(digit_en), 32'(exp_en));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
    endtask

    task automatic cycle(input bit rst, input bit ld, input logic [15:0] v,
                         input logic [3:0] dd, input logic [3:0] bb);
        bit   wrap_now;
        img_t in_img;
        reset        = rst;
        load         = ld;
        digit_values = v;
        dp_in        = dd;
        blank_in     = bb;
        in_img       = '{v: v, d: dd, b: bb};
        @(posedge clk);
        if (rst) begin
            rst_edge = 1'b1;
            k        = 0;
            stage    = RST_IMG;
            act      = RST_IMG;
            shown    = RST_IMG;
            pending  = 1'b0;
        end else begin
            rst_edge = 1'b0;
            wrap_now = (((k + 1) % FRAME) == 0);
            shown    = act;
            if (ld) stage = in_img;
            if (wrap_now) begin
                if (ld) act = in_img;
                else if (pending) act = stage;
                pending = 1'b0;
            end else if (ld) begin
                pending = 1'b1;
            end
            k++;
        end
        @(negedge clk);
        load = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
        end
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i < FRAME && (k % FRAME) != target; i++) begin
            idle(1);
        end
    endtask

    task automatic count_frames(input int n);
        fdn = 0;
        for (int i = 0; i < n; i++) begin
            idle(1);
            if (frame_done) fdn++;
        end
    endtask

    initial begin
        phase = "reset";
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
        end

        phase = "idle";
        count_frames(32);
        check("frame_count_idle", 32'(fdn), 32'd2);

        phase = "load_mid";
        advance_to(5);
        cycle(1'b0, 1'b1, 16'h1A2F, 4'b0100, 4'b0000);
        idle(40);

        phase = "load_wrap";
        advance_to(FRAME - 1);
        check("wrap_aligned", 32'(frame_done), 32'd1);
        cycle(1'b0, 1'b1, 16'h0008, 4'b0000, 4'b0000);
        idle(36);

        phase = "two_loads";
        advance_to(2);
        cycle(1'b0, 1'b1, 16'h1111, 4'b0000, 4'b0000);
        idle(3);
        cycle(1'b0, 1'b1, 16'h2222, 4'b0000, 4'b0000);
        idle(36);

        phase = "blank_dp";
        advance_to(4);
        cycle(1'b0, 1'b1, 16'($urandom), 4'b1000, 4'b1000);
        idle(36);

        phase = "reset_mid";
        advance_to(1);
        cycle(1'b0, 1'b1, 16'($urandom), 4'($urandom), 4'b0000);
        idle(6);
        cycle(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
        cycle(1'b1, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
        count_frames(32);
        check("frame_count_after_reset", 32'(fdn), 32'd2);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                  16'($urandom), 4'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
